// File: rtl/segment_pkg.sv
// segment_pkg: shared constants for the 7-segment scroller.
//  - SEG_BLANK and hex glyphs 0-9/A-F. Codes are {a,b,c,d,e,f,g}: bit 6 = segment a,
//    bit 0 = segment g, 1 = lit.
//  - Scroll FSM state encoding.
//  - hex_glyph(): maps a 4-bit value to its glyph.
package segment_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] GLYPH_0 = 7'h7E;
  localparam logic [6:0] GLYPH_1 = 7'h30;
  localparam logic [6:0] GLYPH_2 = 7'h6D;
  localparam logic [6:0] GLYPH_3 = 7'h79;
  localparam logic [6:0] GLYPH_4 = 7'h33;
  localparam logic [6:0] GLYPH_5 = 7'h5B;
  localparam logic [6:0] GLYPH_6 = 7'h5F;
  localparam logic [6:0] GLYPH_7 = 7'h70;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h7B;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h1F;
  localparam logic [6:0] GLYPH_C = 7'h4E;
  localparam logic [6:0] GLYPH_D = 7'h3D;
  localparam logic [6:0] GLYPH_E = 7'h4F;
  localparam logic [6:0] GLYPH_F = 7'h47;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } scroll_state_t;

  function automatic logic [6:0] hex_glyph(input logic [3:0] value);
    logic [6:0] glyph;
    glyph = SEG_BLANK;
    case (value)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      default: glyph = GLYPH_F;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seg_char_fifo.sv
// seg_char_fifo: small synchronous FIFO for segment codes.
// Ports:
//  clk, reset      clock, asynchronous active-high reset (clears pointers and count)
//  push, push_data write request / data; ignored while full
//  pop             read request; ignored while empty
//  pop_data        entry at the head (valid while !empty)
//  full, empty     status
//  count           entries held, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module seg_char_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 7,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/segment_scroller.sv
// segment_scroller: N-digit multiplexed 7-segment scroller.
// Codes are queued in a FIFO, shifted one per scroll period into a right-to-left
// display register, and time-multiplexed onto a shared segment bus.
// Ports:
//  clk, reset   clock, asynchronous active-high reset
//  enable       low blanks seg_out/digit_sel and freezes the mux/scroll counters
//  char_valid   char_data valid; accepted when char_ready is high
//  char_data    raw segment code {a..g}
//  char_ready   FIFO not full
//  seg_out      segments for the selected digit (registered)
//  digit_sel    one-hot digit enable, bit 0 = rightmost (registered)
//  fifo_count   entries held in the FIFO
//  busy         scroll FSM in RUN
//  brightness   4-bit duty, only when SEG_SCROLL_PWM_EN is defined
// Build option: SEG_SCROLL_PWM_EN adds per-slot PWM gating of digit_sel.
//
// state   | meaning
// ST_IDLE | nothing scrolled since the FIFO last ran dry; display held
// ST_RUN  | a code was shifted in at the last scroll tick
module segment_scroller
  import segment_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int FIFO_DEPTH    = 8,
  parameter int MUX_DIV       = 64,
  parameter int SCROLL_FRAMES = 30,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  char_valid,
  input  logic [6:0]            char_data,
  output logic                  char_ready,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [CW-1:0]         fifo_count,
`ifdef SEG_SCROLL_PWM_EN
  input  logic [3:0]            brightness,
`endif
  output logic                  busy
);

  localparam int SW = $clog2(MUX_DIV);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  logic [SW-1:0] slot_cnt;
  logic [DW-1:0] digit_idx;
  logic [FW-1:0] frame_cnt;
  logic          slot_wrap;
  logic          frame_tick;
  logic          scroll_tick;
  logic          pwm_on;

  logic [NUM_DIGITS-1:0][6:0] display;
  scroll_state_t              state;

  logic       fifo_full;
  logic       fifo_empty;
  logic [6:0] fifo_data;
  logic       pop_req;

  assign slot_wrap   = (slot_cnt == SW'(MUX_DIV - 1));
  assign frame_tick  = slot_wrap && (digit_idx == DW'(NUM_DIGITS - 1));
  assign scroll_tick = enable && frame_tick && (frame_cnt == FW'(SCROLL_FRAMES - 1));
  assign pop_req     = scroll_tick && !fifo_empty;
  assign char_ready  = !fifo_full;

  seg_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (7)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (char_valid),
    .push_data (char_data),
    .pop       (pop_req),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef SEG_SCROLL_PWM_EN
  // Each slot is split into 16 equal phases; the digit is lit for the first
  // 'brightness' of them.
  logic [SW-1:0] phase;
  assign phase  = slot_cnt / SW'(MUX_DIV / 16);
  assign pwm_on = (phase < SW'(brightness));
`else
  assign pwm_on = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
      frame_cnt <= '0;
    end else if (enable) begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + SW'(1);
      if (slot_wrap) begin
        digit_idx <= (digit_idx == DW'(NUM_DIGITS - 1)) ? '0 : digit_idx + DW'(1);
      end
      if (frame_tick) begin
        frame_cnt <= (frame_cnt == FW'(SCROLL_FRAMES - 1)) ? '0 : frame_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      display <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop_req) begin
            display <= {display[NUM_DIGITS-2:0], fifo_data};
            state   <= ST_RUN;
            busy    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (pop_req) begin
            display <= {display[NUM_DIGITS-2:0], fifo_data};
          end else if (scroll_tick) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_out   <= SEG_BLANK;
      digit_sel <= '0;
    end else if (!enable) begin
      seg_out   <= SEG_BLANK;
      digit_sel <= '0;
    end else begin
      seg_out   <= display[digit_idx];
      digit_sel <= pwm_on ? (NUM_DIGITS'(1) << digit_idx) : '0;
    end
  end

endmodule

// File: tb/tb_segment_scroller.sv
module tb_segment_scroller;

  localparam int ND = 4;
  localparam int FD = 4;
  localparam int MD = 16;
  localparam int SF = 2;
  localparam int P  = ND * MD * SF;
  localparam int CW = $clog2(FD + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          char_valid;
  logic [6:0]    char_data;
  logic          char_ready;
  logic [6:0]    seg_out;
  logic [ND-1:0] digit_sel;
  logic [CW-1:0] fifo_count;
  logic          busy;
`ifdef SEG_SCROLL_PWM_EN
  logic [3:0]    brightness;
`endif

  always #5 clk = ~clk;

  segment_scroller #(
    .NUM_DIGITS    (ND),
    .FIFO_DEPTH    (FD),
    .MUX_DIV       (MD),
    .SCROLL_FRAMES (SF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .seg_out    (seg_out),
    .digit_sel  (digit_sel),
    .fifo_count (fifo_count),
`ifdef SEG_SCROLL_PWM_EN
    .brightness (brightness),
`endif
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0]    seg;
    logic [ND-1:0] sel;
    int            cnt;
    bit            bsy;
    bit            rdy;
  } exp_t;

  exp_t sb[$];

  // Reference model: one enabled-cycle counter over the scroll period, a code
  // queue and an array of displayed digits.
  int         m_t;
  logic [6:0] m_q[$];
  logic [6:0] m_disp[ND];
  bit         m_busy;

  always @(posedge clk) begin : model
    exp_t          e;
    int            dig;
    bit            push, scroll, pop;
    logic [ND-1:0] one;
    one = 1;
    if (reset) begin
      m_t = 0;
      m_q.delete();
      foreach (m_disp[i]) m_disp[i] = 7'h00;
      m_busy = 0;
      e = '{seg: 7'h00, sel: '0, cnt: 0, bsy: 1'b0, rdy: 1'b1};
    end else begin
      dig    = (m_t / MD) % ND;
      push   = char_valid && (m_q.size() < FD);
      scroll = enable && (m_t == P - 1);
      pop    = scroll && (m_q.size() > 0);
      e.seg  = enable ? m_disp[dig] : 7'h00;
      e.sel  = enable ? (one << dig) : '0;
`ifdef SEG_SCROLL_PWM_EN
      if (((m_t % MD) / (MD / 16)) >= int'(brightness)) e.sel = '0;
`endif
      if (pop) begin
        for (int i = ND - 1; i > 0; i--) m_disp[i] = m_disp[i-1];
        m_disp[0] = m_q.pop_front();
        m_busy = 1;
      end else if (scroll) begin
        m_busy = 0;
      end
      if (push) m_q.push_back(char_data);
      if (enable) m_t = (m_t + 1) % P;
      e.cnt = m_q.size();
      e.bsy = m_busy;
      e.rdy = (m_q.size() < FD);
    end
    sb.push_back(e);
  end

  task automatic cmp_out(input string name, input exp_t e);
    checks++;
    if (seg_out !== e.seg || digit_sel !== e.sel || int'(fifo_count) != e.cnt ||
        busy !== e.bsy || char_ready !== e.rdy) begin
      errors++;
      $display("FAIL %s @%0t: got seg=%h sel=%b cnt=%0d busy=%b ready=%b, expected seg=%h sel=%b cnt=%0d busy=%b ready=%b",
               name, $time, seg_out, digit_sel, fifo_count, busy, char_ready,
               e.seg, e.sel, e.cnt, e.bsy, e.rdy);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      sb.delete();
      cmp_out("reset_out", '{seg: 7'h00, sel: '0, cnt: 0, bsy: 1'b0, rdy: 1'b1});
    end else if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty @%0t: got no expected entry, expected one per cycle", $time);
    end else begin
      e = sb.pop_front();
      cmp_out("out", e);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_code(input logic [6:0] c);
    char_valid = 1'b1;
    char_data  = c;
    step();
    char_valid = 1'b0;
  endtask

  // Advance until the next clock edge will be a scroll tick.
  task automatic wait_tick_edge(input string name);
    int k = 0;
    while (m_t != P - 1 && k < 2 * P) begin
      step();
      k++;
    end
    checks++;
    if (m_t != P - 1) begin
      errors++;
      $display("FAIL %s timeout @%0t: got no scroll tick, expected one within %0d cycles", name, $time, 2 * P);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog @%0t: got no finish, expected end of test", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lit;
    int k;
    reset      = 1'b1;
    enable     = 1'b0;
    char_valid = 1'b0;
    char_data  = 7'h00;
`ifdef SEG_SCROLL_PWM_EN
    brightness = 4'd15;
`endif
    step(3);
    chk("rst_seg", 32'(seg_out), 0);
    chk("rst_sel", 32'(digit_sel), 0);
    chk("rst_ready", 32'(char_ready), 1);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_busy", 32'(busy), 0);

    reset  = 1'b0;
    enable = 1'b1;
    for (int d = 0; d < ND; d++) begin
      step();
      chk("digit_cycle", 32'(digit_sel), 32'(1 << d));
      step(MD - 1);
    end

    push_code(7'h06);
    push_code(7'h5B);
    chk("count_two", 32'(fifo_count), 2);

    wait_tick_edge("tick1");
    step();
    chk("busy_run", 32'(busy), 1);
    step();
    chk("disp0_first", 32'(seg_out), 32'h06);

    wait_tick_edge("tick2");
    step(2);
    chk("disp0_second", 32'(seg_out), 32'h5B);
    step(MD);
    chk("disp1_second", 32'(seg_out), 32'h06);

    wait_tick_edge("tick3");
    step();
    chk("busy_idle", 32'(busy), 0);
    step();
    chk("disp_held", 32'(seg_out), 32'h5B);

    // Back-to-back fill; the fifth code must be dropped.
    char_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      char_data = 7'($urandom);
      step();
      chk("fill_ready", 32'(char_ready), (i < 3) ? 1 : 0);
    end
    char_valid = 1'b0;
    chk("fill_count", 32'(fifo_count), 4);

    wait_tick_edge("drain1");
    step();
    wait_tick_edge("drain2");
    step();
    chk("drain_count", 32'(fifo_count), 2);

    // Push landing on the same edge as a scroll pop.
    wait_tick_edge("coincide");
    char_valid = 1'b1;
    char_data  = 7'($urandom);
    step();
    char_valid = 1'b0;
    chk("coincide_count", 32'(fifo_count), 2);

    repeat (3000) begin
      char_valid = ($urandom_range(0, 7) == 0);
      char_data  = 7'($urandom);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
`ifdef SEG_SCROLL_PWM_EN
      if ($urandom_range(0, 199) == 0) brightness = 4'($urandom);
`endif
      step();
    end
    char_valid = 1'b0;
    enable     = 1'b1;

`ifdef SEG_SCROLL_PWM_EN
    brightness = 4'd4;
    k = 0;
    while ((m_t % MD) != 0 && k < 2 * MD) begin
      step();
      k++;
    end
    lit = 0;
    repeat (MD) begin
      step();
      if (digit_sel != '0) lit++;
    end
    chk("pwm_b4", 32'(lit), 4);
    brightness = 4'd0;
    lit = 0;
    repeat (MD) begin
      step();
      if (digit_sel != '0) lit++;
    end
    chk("pwm_b0", 32'(lit), 0);
    brightness = 4'd15;
`endif

    // Reset in the middle of RUN.
    push_code(7'($urandom));
    push_code(7'($urandom));
    push_code(7'($urandom));
    k = 0;
    while (!m_busy && k < 2 * P) begin
      step();
      k++;
    end
    chk("reach_run", 32'(busy), 1);
    step(5);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_count", 32'(fifo_count), 0);
    chk("midrst_seg", 32'(seg_out), 0);
    step(2);
    reset = 1'b0;

    // Disable: outputs blank next cycle and no scrolling happens.
    step(40);
    enable = 1'b0;
    step();
    chk("dis_seg", 32'(seg_out), 0);
    chk("dis_sel", 32'(digit_sel), 0);
    push_code(7'h3F);
    push_code(7'h66);
    step(2 * P);
    chk("dis_frozen_count", 32'(fifo_count), 2);
    chk("dis_frozen_busy", 32'(busy), 0);
    enable = 1'b1;
    step(3 * P);
    chk("resume_count", 32'(fifo_count), 0);

    step(2);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
